fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have ports: pc  in  32  current PC register value.
REQ-004 SHALL have ports: new_pc  out  32  next value for the PC register, combinational.
REQ-005 SHALL have ports: redirect  in  1  branch/jump redirect strobe; redirect_pc  in  32  target.
REQ-006 SHALL have ports: imem_req  out  1  fetch request strobe; imem_addr  out  32  fetch address.
REQ-007 SHALL have ports: imem_rvalid  in  1  response strobe; imem_rdata  in  32  instruction word.
REQ-008 SHALL have ports: if_valid  out  1; if_instr  out  32; if_pc  out  32; if_pc4  out  32  registered instruction to decode.
REQ-009 SHALL have ports: id_ready  in  1  decode accepts the held instruction this cycle.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT, DROP, with at most one memory request outstanding.
REQ-011 SHALL define "slot free" as if_valid==0 or (if_valid and id_ready).
REQ-012 IDLE, redirect==0, slot free: imem_req=1, imem_addr={pc[31:2],2'b00}; capture pc into req_pc; new_pc=pc+4; next state WAIT.
REQ-013 IDLE, slot not free: imem_req=0, new_pc=pc, remain IDLE.
REQ-014 imem_req SHALL be high for exactly one cycle per request; it is 0 in WAIT and DROP.
REQ-015 WAIT, imem_rvalid=1, redirect=0: load if_instr=imem_rdata, if_pc=req_pc, if_pc4=req_pc+4, if_valid=1 next edge; next state IDLE.
REQ-016 WAIT, imem_rvalid=0: new_pc=pc, remain WAIT, any number of cycles.
REQ-017 redirect=1 (any state) SHALL take priority: new_pc=redirect_pc, no request issued, if_valid cleared next edge.
REQ-018 Redirect in WAIT without rvalid SHALL go to DROP; with rvalid in the same cycle SHALL discard the response and go to IDLE.
REQ-019 DROP: imem_rvalid=1 SHALL discard the response and go to IDLE; redirect in DROP SHALL update new_pc and remain DROP.
REQ-020 imem_rvalid in IDLE SHALL be ignored with no state change.
REQ-021 if_valid and id_ready with no new load SHALL clear if_valid next edge; if_instr/if_pc/if_pc4 hold value while if_valid=1 and id_ready=0.
REQ-022 new_pc default (no advance, no redirect) SHALL equal pc.
REQ-023 pc+4 and req_pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).
REQ-024 Minimum latency SHALL be: request at cycle N, rvalid at N+1, if_valid=1 at N+2.
REQ-025 A response SHALL never overwrite an unconsumed if_valid entry (REQ-011 guarantees this).

Reset
REQ-026 reset=0 SHALL asynchronously force state IDLE, if_valid=0, if_instr=0, if_pc=0, if_pc4=0, req_pc=0.
REQ-027 During reset imem_req SHALL be 0 and new_pc SHALL equal pc.
REQ-028 Reset mid-WAIT or mid-DROP SHALL abandon the request; a late rvalid after release SHALL be ignored per REQ-020.
REQ-029 The first request SHALL be issued on the first rising edge at which reset=1 and the slot is free.

Verification
REQ-030 Streaming: pc=0 at release, 1-cycle memory, id_ready=1 -> imem_addr 0,4,8 on alternate cycles; if_pc 0,4,8 with matching if_instr; new_pc=pc+4 on request cycles only.
REQ-031 Backpressure: id_ready=0 while if_valid=1 -> no imem_req, new_pc=pc, if_* stable; id_ready=1 -> next request issued that same cycle.
REQ-032 Redirect in flight: redirect=1, redirect_pc=0x100 during WAIT, rvalid 3 cycles later -> response dropped, if_valid stays 0, next imem_addr=0x100.
REQ-033 Same-cycle rvalid and redirect -> response discarded, state IDLE, new_pc=redirect_pc.
REQ-034 Wrap: pc=0xFFFFFFFC -> new_pc=0x00000000, if_pc4=0x00000000.
REQ-035 Reset pulse in WAIT -> all outputs 0 immediately; stray rvalid after release produces no if_valid.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer between the PC register, the
// instruction memory and the decode stage. It keeps at most one memory
// request in flight, holds one fetched instruction for decode, and lets
// branch/jump redirects discard whatever is still in flight.
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active-low
    input  logic [31:0] pc,
    output logic [31:0] new_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    input  logic        id_ready
);

    localparam int DATA_W = 32;

    // IDLE: free to issue; WAIT: request outstanding, response wanted;
    // DROP: request outstanding but its response is to be thrown away.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] DROP = 2'b10;

    // Sequential address step; the add is deliberately truncated so the
    // address space wraps (0xFFFFFFFC -> 0x00000000).
    function automatic logic [DATA_W-1:0] pc_step(input logic [DATA_W-1:0] a);
        pc_step = a + DATA_W'(4);
    endfunction

    logic [1:0]        state_q,    state_d;
    logic [DATA_W-1:0] req_pc_q,   req_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [DATA_W-1:0] if_pc_q,    if_pc_d;
    logic [DATA_W-1:0] if_pc4_q,   if_pc4_d;
    logic              slot_free;

    // The output slot can take a new instruction when it is empty or when
    // decode is draining it this very cycle.
    always_comb begin
        slot_free = !if_valid_q || id_ready;
    end

    // Next-state, request and PC-advance decisions.
    always_comb begin
        state_d    = state_q;
        req_pc_d   = req_pc_q;
        if_valid_d = if_valid_q && !id_ready;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        new_pc     = pc;
        imem_req   = 1'b0;
        imem_addr  = '0;

        // While reset is asserted the flops are forced by the async reset;
        // the combinational outputs are kept quiet (no request, PC holds).
        if (reset) begin
            if (redirect) begin
                // Redirect wins over everything: no request, held entry is
                // flushed, and any outstanding response becomes garbage.
                new_pc     = redirect_pc;
                if_valid_d = 1'b0;
                case (state_q)
                    WAIT:    state_d = imem_rvalid ? IDLE : DROP;
                    DROP:    state_d = imem_rvalid ? IDLE : DROP;
                    default: state_d = IDLE;
                endcase
            end else begin
                case (state_q)
                    IDLE: begin
                        // Stray responses in IDLE are simply ignored.
                        if (slot_free) begin
                            imem_req  = 1'b1;
                            imem_addr = {pc[DATA_W-1:2], 2'b00};
                            req_pc_d  = pc;
                            new_pc    = pc_step(pc);
                            state_d   = WAIT;
                        end
                    end
                    WAIT: begin
                        // The slot was free when the request went out, so
                        // the response can never clobber an unread entry.
                        if (imem_rvalid) begin
                            if_valid_d = 1'b1;
                            if_instr_d = imem_rdata;
                            if_pc_d    = req_pc_q;
                            if_pc4_d   = pc_step(req_pc_q);
                            state_d    = IDLE;
                        end
                    end
                    DROP: begin
                        if (imem_rvalid) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State and decode-facing registers, cleared by the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_pc_q   <= '0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
        end
    end

    // Registered view handed to decode.
    always_comb begin
        if_valid = if_valid_q;
        if_instr = if_instr_q;
        if_pc    = if_pc_q;
        if_pc4   = if_pc4_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scripted bench for fetch_ctrl with a latency-programmable
// memory model and a scoreboard of expected decode entries.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] new_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        id_ready;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;

    entry_t      sb_q[$];
    int          n_chk;
    int          n_pass;
    bit          pc_follow;
    bit          outstanding;
    bit          mem_busy;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .new_pc      (new_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        instr_of = a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    // One clock: scoreboard bookkeeping on pre-edge values, then the PC
    // register and the memory model update just after the edge.
    task automatic tick();
        logic        req;
        logic [31:0] addr;
        logic [31:0] nxt;
        entry_t      e;
        req  = imem_req;
        addr = imem_addr;
        nxt  = new_pc;
        if (if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_spurious_valid", {31'd0, if_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_if_pc", if_pc, e.pc);
                chk("sb_if_instr", if_instr, e.instr);
                chk("sb_if_pc4", if_pc4, e.pc4);
            end
        end
        if (redirect && outstanding) begin
            void'(sb_q.pop_back());
            outstanding = 1'b0;
        end else if (imem_rvalid && outstanding) begin
            outstanding = 1'b0;
        end
        if (req) begin
            e.pc    = pc;
            e.instr = instr_of({pc[31:2], 2'b00});
            e.pc4   = pc + 32'd4;
            sb_q.push_back(e);
            outstanding = 1'b1;
            mem_busy    = 1'b1;
            mem_cnt     = mem_lat;
            mem_addr    = addr;
        end
        @(posedge clk);
        #1;
        if (pc_follow) pc = nxt;
        imem_rvalid = 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        pc_follow = 0; outstanding = 0; mem_busy = 0; mem_cnt = 0; mem_lat = 1;
        mem_addr = '0;
        reset = 1'b0; pc = 32'h40; redirect = 1'b1; redirect_pc = 32'h999;
        imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b1;

        // Reset state: quiet outputs, PC holds even with a redirect pending
        #2;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_new_pc", new_pc, 32'h40);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc4", if_pc4, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        redirect = 1'b0; pc = 32'h0; pc_follow = 1; reset = 1'b1;
        #1;

        // Streaming with 1-cycle memory
        for (int i = 0; i < 6; i++) begin
            chk("str_imem_req", {31'd0, imem_req}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("str_new_pc", new_pc, (i % 2 == 0) ? pc + 32'd4 : pc);
            if (i % 2 == 0) chk("str_imem_addr", imem_addr, 32'(4 * (i / 2)));
            chk("str_if_valid", {31'd0, if_valid}, (i >= 2 && i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // Backpressure: entry for 0x8 held, nothing issued
        id_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_imem_req", {31'd0, imem_req}, 32'd0);
            chk("bp_new_pc", new_pc, 32'hC);
            chk("bp_if_valid", {31'd0, if_valid}, 32'd1);
            chk("bp_if_pc", if_pc, 32'h8);
            chk("bp_if_instr", if_instr, instr_of(32'h8));
            tick();
        end
        id_ready = 1'b1;
        #1;
        chk("bp_release_req", {31'd0, imem_req}, 32'd1);
        chk("bp_release_addr", imem_addr, 32'hC);
        tick();
        tick();

        // Redirect while waiting on a 3-cycle response
        mem_lat = 3;
        chk("rf_req_addr", imem_addr, 32'h10);
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        chk("rf_new_pc", new_pc, 32'h100);
        chk("rf_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("rf_drop_req", {31'd0, imem_req}, 32'd0);
        chk("rf_drop_new_pc", new_pc, 32'h100);
        tick();
        chk("rf_late_rvalid", {31'd0, imem_rvalid}, 32'd1);
        chk("rf_drop_req2", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rf_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rf_next_req", {31'd0, imem_req}, 32'd1);
        chk("rf_next_addr", imem_addr, 32'h100);

        // Same-cycle response and redirect
        mem_lat = 1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h300;
        #1;
        chk("sc_new_pc", new_pc, 32'h300);
        tick();
        redirect = 1'b0;
        #1;
        chk("sc_if_valid", {31'd0, if_valid}, 32'd0);
        chk("sc_idle_req", {31'd0, imem_req}, 32'd1);
        chk("sc_idle_addr", imem_addr, 32'h300);

        // Redirect again while in DROP: stays in DROP
        mem_lat = 3;
        tick();
        redirect = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h500;
        #1;
        chk("dr_new_pc", new_pc, 32'h500);
        chk("dr_no_req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("dr_rvalid_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("dr_next_addr", imem_addr, 32'h500);
        chk("dr_if_valid", {31'd0, if_valid}, 32'd0);

        // Wrap at the top of the address space
        mem_lat = 1;
        tick();
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wr_redir_new_pc", new_pc, 32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        #1;
        chk("wr_if_valid_clr", {31'd0, if_valid}, 32'd0);
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wr_new_pc", new_pc, 32'h0);
        tick();
        tick();
        chk("wr_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wr_if_pc4", if_pc4, 32'h0);

        // Reset pulse mid-WAIT, then a stray response after release
        mem_lat = 3;
        tick();
        reset = 1'b0;
        #1;
        chk("rw_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rw_if_instr", if_instr, 32'd0);
        chk("rw_if_pc", if_pc, 32'd0);
        chk("rw_if_pc4", if_pc4, 32'd0);
        chk("rw_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rw_imem_addr", imem_addr, 32'd0);
        chk("rw_new_pc", new_pc, 32'h4);
        sb_q.delete();
        outstanding = 1'b0;
        mem_busy = 1'b0;
        tick();
        reset = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        mem_lat = 2;
        #1;
        chk("rw_first_req", {31'd0, imem_req}, 32'd1);
        chk("rw_first_addr", imem_addr, 32'h4);
        tick();
        chk("rw_stray_ignored", {31'd0, if_valid}, 32'd0);
        tick();
        tick();
        chk("rw_if_valid_new", {31'd0, if_valid}, 32'd1);
        chk("rw_if_pc_new", if_pc, 32'h4);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
